rgb_led_arbiter: RTL and testbench
==================================

RGB_LED_ARBITER -- requirements
Module: rgb_led_arbiter

Parameters
REQ-001 N_REQ, default 3: number of requesters sharing the RGB LED.
REQ-002 PWM_BITS, default 8: duty resolution per colour channel.
REQ-003 MIN_HOLD, default 4: minimum ownership time, in PWM periods.
REQ-004 MAX_HOLD, default 64: ownership limit, in PWM periods, when another requester is waiting.
REQ-005 GAP_CYCLES, default 16: dark clock cycles between owners.

Interface
REQ-006 clk48  in  1  sole clock; all state on its rising edge.
REQ-007 rst  in  1  asynchronous reset, active-high.
REQ-008 req  in  N_REQ  per-requester ownership request, level-sensitive.
REQ-009 color  in  N_REQ*3*PWM_BITS  per-requester {R,G,B} duty values, requester 0 in the LSBs.
REQ-010 gnt  out  N_REQ  one-hot grant, or all-zero.
REQ-011 busy  out  1  high while any grant is active.
REQ-012 rgb_led0_r / rgb_led0_g / rgb_led0_b  out  1 each  LED drives, active-low (0 = lit).

Function
REQ-013 The FSM SHALL have three states:
- IDLE: no grant, LEDs dark.
- OWN: one grant active, PWM running.
- GAP: no grant, LEDs dark, GAP_CYCLES counter running.
REQ-014 In IDLE with any req high, the block SHALL grant the first requester at or after the round-robin pointer, wrapping modulo N_REQ; gnt and busy go high on the next edge.
REQ-015 On entry to OWN:
- PWM counter SHALL load 0.
- The period count SHALL clear.
- The owner's colour SHALL latch.
REQ-016 PWM counter SHALL count 0..2^PWM_BITS-2 and wrap (period 255 cycles at default); each wrap increments the period count, saturating at MAX_HOLD.
REQ-017 Owner's colour SHALL re-latch only at each wrap; colour changes mid-period take effect at the next period.
REQ-018 Channel lit when counter < latched duty, registered (one cycle latency):
- duty 0: never lit.
- duty 2^PWM_BITS-1: always lit.
REQ-019 OWN SHALL exit to GAP when either condition holds:
- Owner req low and period count >= MIN_HOLD.
- Period count = MAX_HOLD and any other req high (preemption).
REQ-020 Owner req dropping before MIN_HOLD SHALL NOT end the grant; the grant holds until MIN_HOLD periods complete.
REQ-021 With no other requester waiting, MAX_HOLD SHALL NOT preempt; ownership continues indefinitely.
REQ-022 On exit from OWN, on the same edge:
- gnt and busy SHALL clear.
- LEDs SHALL go dark (all outputs 1).
- Pointer SHALL become owner+1 modulo N_REQ.
REQ-023 GAP SHALL last exactly GAP_CYCLES cycles, then return to IDLE; requests asserted during GAP are arbitrated in IDLE.
REQ-024 Simultaneous requests SHALL resolve by pointer order only; there is no fixed priority.
REQ-025 gnt SHALL never have more than one bit set; busy SHALL equal OR of gnt.

Reset
REQ-026 While rst is high, without any clock edge:
- gnt = 0, busy = 0, rgb_led0_r/g/b = 1.
- State = IDLE, pointer = 0, all counters = 0.
REQ-027 rst asserted mid-OWN or mid-GAP SHALL abort immediately; there is no GAP after reset.
REQ-028 The first arbitration SHALL occur on the first edge after rst deasserts.

Verification
REQ-029 req=001, color0 R=255 G=0 B=0 after reset -> gnt=001 after 1 edge; rgb_led0_r=0 continuously from the next cycle; g and b stay 1.
REQ-030 color0 R=64 -> rgb_led0_r low for exactly 64 of every 255 cycles; changing R to 128 mid-period -> 64 cycles this period, 128 the next.
REQ-031 req=011 from reset, req0 dropped after 5 periods -> gnt=001, then 16 cycles with gnt=000 and LEDs all 1, then gnt=010.
REQ-032 req0 held continuously, req2 raised at period 10 -> gnt=001 drops after period 64 (64*255 cycles), 16-cycle gap, gnt=100; when req2 drops after MIN_HOLD, req0 is regranted.
REQ-033 req0 single-cycle pulse -> gnt=001 held exactly 4 periods (1020 cycles), then GAP.
REQ-034 rst pulsed mid-OWN between clock edges -> gnt, busy = 0 and LEDs = 1 immediately; after release with req=100, gnt=100 (pointer reset to 0, search wraps).

Source files
------------

// File: rtl/rgb_led_arbiter_if.sv
// ---------------------------------------------------------------------------
// rgb_led_arbiter_if
// Bundles the requester-facing signals of the RGB LED arbiter.
//   req         requester -> arbiter  one level-sensitive request per requester
//   color       requester -> arbiter  {R,G,B} duty per requester, requester 0 in the LSBs
//   gnt         arbiter -> requester  one-hot grant, or all-zero
//   busy        arbiter -> requester  high while any grant is active
//   rgb_led0_*  arbiter -> LED pins   active-low colour drives (0 = lit)
// The master modport is the requester/board side, the slave modport is the arbiter.
// ---------------------------------------------------------------------------
interface rgb_led_arbiter_if #(
    parameter int N_REQ    = 3,
    parameter int PWM_BITS = 8
);
    logic [N_REQ-1:0]            req;
    logic [N_REQ*3*PWM_BITS-1:0] color;
    logic [N_REQ-1:0]            gnt;
    logic                        busy;
    logic                        rgb_led0_r;
    logic                        rgb_led0_g;
    logic                        rgb_led0_b;

    modport master (
        output req,
        output color,
        input  gnt,
        input  busy,
        input  rgb_led0_r,
        input  rgb_led0_g,
        input  rgb_led0_b
    );

    modport slave (
        input  req,
        input  color,
        output gnt,
        output busy,
        output rgb_led0_r,
        output rgb_led0_g,
        output rgb_led0_b
    );
endinterface

// File: rtl/rgb_led_arbiter.sv
// ---------------------------------------------------------------------------
// rgb_led_arbiter
// Shares one RGB LED between N_REQ requesters. A round-robin arbiter hands out
// ownership; the owner's colour is shown with a PWM_BITS-bit PWM per channel.
// Ownership lasts at least MIN_HOLD PWM periods and is preempted after
// MAX_HOLD periods only if someone else is waiting. Between owners the LED
// stays dark for GAP_CYCLES clock cycles.
// Ports:
//   clk48  sole clock, rising edge
//   rst    asynchronous reset, active-high
//   bus    slave side of rgb_led_arbiter_if (req, color, gnt, busy, LED drives)
// ---------------------------------------------------------------------------
module rgb_led_arbiter #(
    parameter int N_REQ      = 3,
    parameter int PWM_BITS   = 8,
    parameter int MIN_HOLD   = 4,
    parameter int MAX_HOLD   = 64,
    parameter int GAP_CYCLES = 16
) (
    input  logic                clk48,
    input  logic                rst,
    rgb_led_arbiter_if.slave    bus
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PER_W = $clog2(MAX_HOLD + 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int CW    = 3 * PWM_BITS;

    localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((1 << PWM_BITS) - 2);
    localparam logic [PER_W-1:0]    PER_MAX  = PER_W'(MAX_HOLD);
    localparam logic [PER_W-1:0]    PER_MIN  = PER_W'(MIN_HOLD);
    localparam logic [GAP_W-1:0]    GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [PTR_W-1:0]    PTR_LAST = PTR_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t              state_q;
    logic [PTR_W-1:0]    ptr_q;
    logic [PTR_W-1:0]    owner_q;
    logic [N_REQ-1:0]    gnt_q;
    logic                busy_q;
    logic                ledR_q;
    logic                ledG_q;
    logic                ledB_q;
    logic [PWM_BITS-1:0] pwmCnt_q;
    logic [PER_W-1:0]    period_q;
    logic [GAP_W-1:0]    gapCnt_q;
    logic [PWM_BITS-1:0] dutyR_q;
    logic [PWM_BITS-1:0] dutyG_q;
    logic [PWM_BITS-1:0] dutyB_q;

    logic [CW-1:0]       colorArr [N_REQ];
    logic [CW-1:0]       ownerColor;
    logic [CW-1:0]       pickColor;
    logic                pickValid;
    logic [PTR_W-1:0]    pickIdx;
    logic [N_REQ-1:0]    pickOneHot;
    logic                wrap;
    logic [PER_W-1:0]    period_d;
    logic [PTR_W-1:0]    ptr_d;
    logic                othersWaiting;
    logic                exitOwn;
    logic                gapDone;
    logic                grantNow;

    // Slice the flat colour bus into one {R,G,B} word per requester so the
    // owner's and the candidate's colours can be picked with a plain index.
    for (genvar g = 0; g < N_REQ; g++) begin : gColor
        assign colorArr[g] = bus.color[g*CW +: CW];
    end

    assign ownerColor = colorArr[owner_q];
    assign pickColor  = colorArr[pickIdx];
    assign pickOneHot = N_REQ'(1) << pickIdx;

    // Round-robin search: walk the offsets from the highest down so the
    // requester closest at-or-after the pointer is the one left standing.
    always_comb begin
        logic [PTR_W-1:0] candIdx;
        pickValid = 1'b0;
        pickIdx   = '0;
        candIdx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            candIdx = PTR_W'((int'(ptr_q) + i) % N_REQ);
            if (bus.req[candIdx]) begin
                pickValid = 1'b1;
                pickIdx   = candIdx;
            end
        end
    end

    // Ownership bookkeeping. The exit test looks at the period count as it
    // will be after this edge, so a hold of MIN_HOLD periods ends exactly on
    // the wrap that completes the last period rather than one cycle later.
    // The end of the gap doubles as an arbitration cycle, which keeps the dark
    // time between two owners at exactly GAP_CYCLES.
    always_comb begin
        wrap          = (pwmCnt_q == PWM_LAST);
        period_d      = (wrap && (period_q != PER_MAX)) ? period_q + PER_W'(1) : period_q;
        othersWaiting = |(bus.req & ~gnt_q);
        exitOwn       = (!bus.req[owner_q] && (period_d >= PER_MIN))
                     || ((period_d == PER_MAX) && othersWaiting);
        gapDone       = (gapCnt_q == GAP_LAST);
        grantNow      = pickValid && ((state_q == IDLE) || ((state_q == GAP) && gapDone));
        ptr_d         = (owner_q == PTR_LAST) ? '0 : owner_q + PTR_W'(1);
    end

    // Main FSM with registered outputs. Reset is asynchronous so the LED goes
    // dark and the grant drops the moment rst rises, with no trailing gap.
    // In OWN the LED registers compare the running counter with the latched
    // duty, giving one cycle of latency; colours re-latch only on a wrap so a
    // mid-period change shows up cleanly in the following period.
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
            ledR_q   <= 1'b1;
            ledG_q   <= 1'b1;
            ledB_q   <= 1'b1;
            pwmCnt_q <= '0;
            period_q <= '0;
            gapCnt_q <= '0;
            dutyR_q  <= '0;
            dutyG_q  <= '0;
            dutyB_q  <= '0;
        end else if (grantNow) begin
            state_q  <= OWN;
            owner_q  <= pickIdx;
            gnt_q    <= pickOneHot;
            busy_q   <= 1'b1;
            ledR_q   <= 1'b1;
            ledG_q   <= 1'b1;
            ledB_q   <= 1'b1;
            pwmCnt_q <= '0;
            period_q <= '0;
            dutyR_q  <= pickColor[3*PWM_BITS-1:2*PWM_BITS];
            dutyG_q  <= pickColor[2*PWM_BITS-1:PWM_BITS];
            dutyB_q  <= pickColor[PWM_BITS-1:0];
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= IDLE;
                end
                OWN: begin
                    if (exitOwn) begin
                        state_q  <= GAP;
                        gnt_q    <= '0;
                        busy_q   <= 1'b0;
                        ledR_q   <= 1'b1;
                        ledG_q   <= 1'b1;
                        ledB_q   <= 1'b1;
                        ptr_q    <= ptr_d;
                        gapCnt_q <= '0;
                    end else begin
                        ledR_q <= !(pwmCnt_q < dutyR_q);
                        ledG_q <= !(pwmCnt_q < dutyG_q);
                        ledB_q <= !(pwmCnt_q < dutyB_q);
                        if (wrap) begin
                            pwmCnt_q <= '0;
                            period_q <= period_d;
                            dutyR_q  <= ownerColor[3*PWM_BITS-1:2*PWM_BITS];
                            dutyG_q  <= ownerColor[2*PWM_BITS-1:PWM_BITS];
                            dutyB_q  <= ownerColor[PWM_BITS-1:0];
                        end else begin
                            pwmCnt_q <= pwmCnt_q + PWM_BITS'(1);
                        end
                    end
                end
                GAP: begin
                    if (gapDone) begin
                        state_q <= IDLE;
                    end else begin
                        gapCnt_q <= gapCnt_q + GAP_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.busy       = busy_q;
    assign bus.rgb_led0_r = ledR_q;
    assign bus.rgb_led0_g = ledG_q;
    assign bus.rgb_led0_b = ledB_q;

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rgb_led_arbiter
// Self-checking bench for rgb_led_arbiter. A behavioural model tracks the
// owner, the age of the grant in cycles and the remaining dark time, and
// derives the expected grant and LED pins from that with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_rgb_led_arbiter;

    localparam int N_REQ      = 3;
    localparam int PWM_BITS   = 8;
    localparam int MIN_HOLD   = 4;
    localparam int MAX_HOLD   = 64;
    localparam int GAP_CYCLES = 16;
    localparam int PERIOD     = (1 << PWM_BITS) - 1;

    logic clk48 = 1'b0;
    logic rst   = 1'b0;

    rgb_led_arbiter_if #(.N_REQ(N_REQ), .PWM_BITS(PWM_BITS)) busIf ();

    rgb_led_arbiter #(
        .N_REQ(N_REQ),
        .PWM_BITS(PWM_BITS),
        .MIN_HOLD(MIN_HOLD),
        .MAX_HOLD(MAX_HOLD),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk48(clk48),
        .rst(rst),
        .bus(busIf)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk48 = ~clk48;

    int total = 0;
    int bad   = 0;

    int colR [N_REQ];
    int colG [N_REQ];
    int colB [N_REQ];

    int mOwner;
    int mAge;
    int mPtr;
    int mGapLeft;
    int mDutyR;
    int mDutyG;
    int mDutyB;
    int eGnt;
    bit eR;
    bit eG;
    bit eB;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic driveColors();
        for (int i = 0; i < N_REQ; i++) begin
            busIf.color[i*3*PWM_BITS +: 3*PWM_BITS] = {PWM_BITS'(colR[i]), PWM_BITS'(colG[i]), PWM_BITS'(colB[i])};
        end
    endtask

    task automatic setColor(input int idx, input int r, input int g, input int b);
        colR[idx] = r;
        colG[idx] = g;
        colB[idx] = b;
        driveColors();
    endtask

    task automatic applyStimulus(input logic [N_REQ-1:0] reqVal);
        busIf.req = reqVal;
    endtask

    task automatic resetModel();
        mOwner   = -1;
        mAge     = 0;
        mPtr     = 0;
        mGapLeft = 0;
        eGnt     = 0;
        eR       = 1'b1;
        eG       = 1'b1;
        eB       = 1'b1;
    endtask

    // One clock edge of the reference behaviour, using the inputs as they
    // stand at the edge. k counts edges since the grant; every PERIOD edges
    // completes one PWM period and refreshes the shown colour.
    task automatic stepModel();
        int  k;
        int  periods;
        int  phase;
        bit  others;
        bit  mayGrant;
        if (rst) begin
            resetModel();
            return;
        end
        if (mOwner >= 0) begin
            k       = mAge + 1;
            periods = k / PERIOD;
            if (periods > MAX_HOLD) periods = MAX_HOLD;
            others  = ((int'(busIf.req) & ~(1 << mOwner)) != 0);
            if ((!busIf.req[mOwner] && periods >= MIN_HOLD) || (periods == MAX_HOLD && others)) begin
                mPtr     = (mOwner + 1) % N_REQ;
                mOwner   = -1;
                mGapLeft = GAP_CYCLES;
                eGnt     = 0;
                eR       = 1'b1;
                eG       = 1'b1;
                eB       = 1'b1;
            end else begin
                phase = (k - 1) % PERIOD;
                eR    = !(phase < mDutyR);
                eG    = !(phase < mDutyG);
                eB    = !(phase < mDutyB);
                if (k % PERIOD == 0) begin
                    mDutyR = colR[mOwner];
                    mDutyG = colG[mOwner];
                    mDutyB = colB[mOwner];
                end
                mAge = k;
            end
        end else begin
            mayGrant = 1'b1;
            if (mGapLeft > 0) begin
                mGapLeft--;
                mayGrant = (mGapLeft == 0);
            end
            if (mayGrant && busIf.req != '0) begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (mOwner < 0 && busIf.req[(mPtr + i) % N_REQ]) mOwner = (mPtr + i) % N_REQ;
                end
                mAge   = 0;
                mDutyR = colR[mOwner];
                mDutyG = colG[mOwner];
                mDutyB = colB[mOwner];
                eGnt   = 1 << mOwner;
                eR     = 1'b1;
                eG     = 1'b1;
                eB     = 1'b1;
            end
        end
    endtask

    // Advance one clock, update the model at the edge, compare just after it.
    task automatic tick();
        logic [31:0] obs;
        logic [31:0] exp;
        @(posedge clk48);
        stepModel();
        #1;
        obs = {25'b0, busIf.gnt, busIf.busy, busIf.rgb_led0_r, busIf.rgb_led0_g, busIf.rgb_led0_b};
        exp = {25'b0, 3'(eGnt), (eGnt != 0), eR, eG, eB};
        checkOutput("cycle", obs, exp);
    endtask

    task automatic applyReset();
        @(negedge clk48);
        rst = 1'b1;
        resetModel();
        tick();
        tick();
        @(negedge clk48);
        rst = 1'b0;
    endtask

    function automatic int pickDuty();
        case ($urandom_range(0, 3))
            0:       return 0;
            1:       return PERIOD;
            default: return int'($urandom_range(0, PERIOD));
        endcase
    endfunction

    // Directed scenarios first, then a long randomized run against the model.
    initial begin
        int cnt;
        int other;
        int n;

        for (int i = 0; i < N_REQ; i++) setColor(i, 0, 0, 0);
        applyStimulus('0);
        resetModel();

        // Reset takes effect with no clock edge.
        #2 rst = 1'b1;
        #1;
        checkOutput("reset_gnt", busIf.gnt, 0);
        checkOutput("reset_busy", busIf.busy, 0);
        checkOutput("reset_leds", {busIf.rgb_led0_r, busIf.rgb_led0_g, busIf.rgb_led0_b}, 3'b111);

        // Full red on requester 0.
        setColor(0, 255, 0, 0);
        applyStimulus(3'b001);
        tick();
        tick();
        @(negedge clk48);
        rst = 1'b0;
        tick();
        checkOutput("first_grant", busIf.gnt, 3'b001);
        checkOutput("first_busy", busIf.busy, 1);
        cnt   = 0;
        other = 0;
        repeat (600) begin
            tick();
            if (!busIf.rgb_led0_r) cnt++;
            if (!busIf.rgb_led0_g || !busIf.rgb_led0_b) other++;
        end
        checkOutput("red_always_lit", cnt, 600);
        checkOutput("green_blue_dark", other, 0);

        // Partial duty, then a mid-period change.
        setColor(0, 64, 0, 0);
        repeat (300) tick();
        cnt = 0;
        repeat (PERIOD) begin
            tick();
            if (!busIf.rgb_led0_r) cnt++;
        end
        checkOutput("duty64_count", cnt, 64);
        setColor(0, 128, 0, 0);
        repeat (300) tick();
        cnt = 0;
        repeat (PERIOD) begin
            tick();
            if (!busIf.rgb_led0_r) cnt++;
        end
        checkOutput("duty128_count", cnt, 128);

        // Two requesters, owner releases after five periods.
        applyStimulus(3'b011);
        applyReset();
        tick();
        checkOutput("grant0_of_011", busIf.gnt, 3'b001);
        repeat (5 * PERIOD + 10) tick();
        applyStimulus(3'b010);
        n = 0;
        while (busIf.gnt != '0 && n < PERIOD) begin
            tick();
            n++;
        end
        cnt = 0;
        n   = 0;
        while (busIf.gnt == '0 && n < 4 * GAP_CYCLES) begin
            cnt++;
            tick();
            n++;
        end
        checkOutput("gap_len_release", cnt, GAP_CYCLES);
        checkOutput("grant1_after_gap", busIf.gnt, 3'b010);

        // Preemption at MAX_HOLD, then regrant of requester 0.
        applyStimulus(3'b001);
        applyReset();
        tick();
        checkOutput("grant0_alone", busIf.gnt, 3'b001);
        cnt = 1;
        repeat (10 * PERIOD) begin
            tick();
            if (busIf.gnt == 3'b001) cnt++;
        end
        applyStimulus(3'b101);
        n = 0;
        while (busIf.gnt == 3'b001 && n < 2 * MAX_HOLD * PERIOD) begin
            tick();
            n++;
            if (busIf.gnt == 3'b001) cnt++;
        end
        checkOutput("max_hold_cycles", cnt, MAX_HOLD * PERIOD);
        cnt = 0;
        n   = 0;
        while (busIf.gnt == '0 && n < 4 * GAP_CYCLES) begin
            cnt++;
            tick();
            n++;
        end
        checkOutput("gap_len_preempt", cnt, GAP_CYCLES);
        checkOutput("grant2_after_preempt", busIf.gnt, 3'b100);
        repeat (5 * PERIOD) tick();
        applyStimulus(3'b001);
        n = 0;
        while (busIf.gnt != 3'b001 && n < PERIOD) begin
            tick();
            n++;
        end
        checkOutput("regrant0", busIf.gnt, 3'b001);

        // Single-cycle request still holds for MIN_HOLD periods.
        applyStimulus(3'b001);
        applyReset();
        tick();
        applyStimulus(3'b000);
        cnt = 1;
        n   = 0;
        while (busIf.gnt == 3'b001 && n < 3 * MIN_HOLD * PERIOD) begin
            tick();
            n++;
            if (busIf.gnt == 3'b001) cnt++;
        end
        checkOutput("pulse_hold_cycles", cnt, MIN_HOLD * PERIOD);
        checkOutput("pulse_then_dark", {busIf.gnt, busIf.rgb_led0_r, busIf.rgb_led0_g, busIf.rgb_led0_b}, 6'b000111);

        // Asynchronous reset in the middle of ownership, then a wrapping search.
        setColor(0, 255, 255, 255);
        applyStimulus(3'b001);
        applyReset();
        repeat (50) tick();
        checkOutput("own_before_reset", busIf.gnt, 3'b001);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_reset_gnt_busy", {busIf.gnt, busIf.busy}, 4'b0000);
        checkOutput("async_reset_leds", {busIf.rgb_led0_r, busIf.rgb_led0_g, busIf.rgb_led0_b}, 3'b111);
        resetModel();
        applyStimulus(3'b100);
        tick();
        @(negedge clk48);
        rst = 1'b0;
        tick();
        checkOutput("grant2_after_reset", busIf.gnt, 3'b100);

        // Randomized traffic with boundary duties and an extra reset midway.
        for (int i = 0; i < N_REQ; i++) setColor(i, pickDuty(), pickDuty(), pickDuty());
        for (int c = 0; c < 20000; c++) begin
            if ($urandom_range(0, 149) == 0) applyStimulus(3'($urandom_range(0, 7)));
            if ($urandom_range(0, 99) == 0) setColor(int'($urandom_range(0, N_REQ - 1)), pickDuty(), pickDuty(), pickDuty());
            if (c == 10000) applyReset();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
